// File: rtl/core_pkg.sv
// Shared core types and constants used by the instruction prefetch stage.
package core_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      DISCARD
   } prefetch_state_t;

   localparam logic [31:0] RESET_VECTOR        = 32'hFFFF_FFF0;
   localparam int          DECODE_WINDOW_BYTES = 16;

endpackage

// File: rtl/prefetch_queue_if.sv
// Prefetch-stage signal bundle: core bus read channel, flush request and decode window.
interface prefetch_queue_if;
   import core_pkg::*;

   logic                                 flush;
   logic [31:0]                          flush_address;
   logic                                 bus_vaild;
   logic                                 bus_ready;
   logic [31:0]                          bus_address;
   logic [31:0]                          bus_data;
   byte_t [DECODE_WINDOW_BYTES-1:0]      window;
   logic [4:0]                           window_valid_bytes;
   logic [31:0]                          window_address;
   logic                                 consume_valid;
   logic [4:0]                           consume_count;

   modport master (
      input  flush, flush_address, bus_ready, bus_data, consume_valid, consume_count,
      output bus_vaild, bus_address, window, window_valid_bytes, window_address
   );

   modport slave (
      output flush, flush_address, bus_ready, bus_data, consume_valid, consume_count,
      input  bus_vaild, bus_address, window, window_valid_bytes, window_address
   );

endinterface

// File: rtl/prefetch_byte_ring.sv
// Circular code-byte store: writes bytes skip..3 of a dword at the write index,
// reads a rotated window starting at the read index.
module prefetch_byte_ring
   import core_pkg::*;
#(
   parameter int DEPTH  = 32,
   parameter int WINDOW = DECODE_WINDOW_BYTES,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                   clock,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_idx,
   input  logic [1:0]             wr_skip,
   input  logic [31:0]            wr_data,
   input  logic [AW-1:0]          rd_idx,
   output byte_t [WINDOW-1:0]     rd_bytes
);

   byte_t mem [DEPTH];

   always_ff @(posedge clock) begin
      if (wr_en) begin
         for (int k = 0; k < 4; k++) begin
            if (k >= int'(wr_skip))
               mem[wr_idx + AW'(k - int'(wr_skip))] <= wr_data[8*k +: 8];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < WINDOW; i++)
         rd_bytes[i] = mem[rd_idx + AW'(i)];
   end

endmodule

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: fetches aligned code dwords into a byte ring and
// presents a window of queued bytes to decode.
//
//   state   | meaning
//   IDLE    | queue lacks room for a dword, no request outstanding
//   REQ     | read request outstanding at bus_address, data is enqueued on ready
//   DISCARD | flushed while a request was pending; finish it and drop the data
module prefetch_queue
   import core_pkg::*;
#(
   parameter int          QUEUE_BYTES   = 32,
   parameter int          WINDOW_BYTES  = DECODE_WINDOW_BYTES,
   parameter logic [31:0] RESET_ADDRESS = RESET_VECTOR
) (
   input logic              clock,
   input logic              reset,
   prefetch_queue_if.master pq
);

   localparam int AW    = $clog2(QUEUE_BYTES);
   localparam int PTR_W = AW + 1;

   prefetch_state_t state;
   logic [PTR_W-1:0] rd_ptr, wr_ptr, count, count_next;
   logic [31:0]      fetch_address, window_address, bus_address, fetch_next;
   logic [1:0]       skip;
   logic             bus_vaild, take, room_next;
   logic [2:0]       enq_n;
   logic [4:0]       wvb, cons;
   byte_t [WINDOW_BYTES-1:0] ring_bytes, win;

   always_comb begin
      wvb        = (count > PTR_W'(WINDOW_BYTES)) ? 5'(WINDOW_BYTES) : count[4:0];
      cons       = '0;
      if (pq.consume_valid)
         cons = (pq.consume_count > wvb) ? wvb : pq.consume_count;
      enq_n      = 3'd4 - {1'b0, skip};
      take       = (state == REQ) && pq.bus_ready && !pq.flush;
      count_next = count + (take ? PTR_W'(enq_n) : '0) - PTR_W'(cons);
      room_next  = count_next <= PTR_W'(QUEUE_BYTES - 4);
      fetch_next = fetch_address + 32'(enq_n);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state          <= IDLE;
         bus_vaild      <= 1'b0;
         bus_address    <= {RESET_ADDRESS[31:2], 2'b00};
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         fetch_address  <= RESET_ADDRESS;
         window_address <= RESET_ADDRESS;
         skip           <= RESET_ADDRESS[1:0];
      end else if (pq.flush) begin
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         count          <= '0;
         fetch_address  <= pq.flush_address;
         window_address <= pq.flush_address;
         skip           <= pq.flush_address[1:0];
         // A request the bus has not yet accepted must still complete at its old address.
         if ((state == REQ || state == DISCARD) && !pq.bus_ready) begin
            state <= DISCARD;
         end else begin
            state       <= REQ;
            bus_vaild   <= 1'b1;
            bus_address <= {pq.flush_address[31:2], 2'b00};
         end
      end else begin
         rd_ptr         <= rd_ptr + PTR_W'(cons);
         window_address <= window_address + 32'(cons);
         count          <= count_next;
         case (state)
            IDLE: begin
               if (room_next) begin
                  state       <= REQ;
                  bus_vaild   <= 1'b1;
                  bus_address <= {fetch_address[31:2], 2'b00};
               end
            end
            REQ: begin
               if (pq.bus_ready) begin
                  wr_ptr        <= wr_ptr + PTR_W'(enq_n);
                  fetch_address <= fetch_next;
                  skip          <= 2'b00;
                  if (room_next) begin
                     bus_address <= {fetch_next[31:2], 2'b00};
                  end else begin
                     state     <= IDLE;
                     bus_vaild <= 1'b0;
                  end
               end
            end
            DISCARD: begin
               if (pq.bus_ready) begin
                  state       <= REQ;
                  bus_address <= {fetch_address[31:2], 2'b00};
               end
            end
            default: begin
               state     <= IDLE;
               bus_vaild <= 1'b0;
            end
         endcase
      end
   end

   prefetch_byte_ring #(
      .DEPTH  (QUEUE_BYTES),
      .WINDOW (WINDOW_BYTES)
   ) u_ring (
      .clock    (clock),
      .wr_en    (take),
      .wr_idx   (wr_ptr[AW-1:0]),
      .wr_skip  (skip),
      .wr_data  (pq.bus_data),
      .rd_idx   (rd_ptr[AW-1:0]),
      .rd_bytes (ring_bytes)
   );

   always_comb begin
      for (int i = 0; i < WINDOW_BYTES; i++)
         win[i] = (5'(i) < wvb) ? ring_bytes[i] : 8'h00;
   end

   assign pq.window             = win;
   assign pq.window_valid_bytes = wvb;
   assign pq.window_address     = window_address;
   assign pq.bus_vaild          = bus_vaild;
   assign pq.bus_address        = bus_address;

   a_consume_legal : assert property (@(posedge clock) disable iff (!reset)
      pq.consume_valid |-> (pq.consume_count <= wvb))
      else $error("consume_count exceeds window_valid_bytes");

endmodule
